// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage. Owns the PC, drives a 1-cycle-latency
//             instruction bank and hands {instr, pc} to decode via valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fault
);

    localparam logic [31:0] c_last_pc = 32'(MEM_BYTES - 4);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FAULT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_inflight_pc;
    logic        r_inflight_valid;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;

    logic        w_stall;
    logic        w_pc_ok;
    logic [31:0] w_target;

    assign w_stall  = r_if_valid && !if_ready;
    assign w_pc_ok  = (r_fetch_pc[1:0] == 2'b00) && (r_fetch_pc <= c_last_pc);
    assign w_target = redirect_target & ~32'h3;

    // The bank has no read enable, so a held word is kept alive by re-reading it.
    assign imem_addr = (w_stall && r_inflight_valid) ? r_inflight_pc : r_fetch_pc;

    assign if_valid = r_if_valid;
    assign if_instr = r_if_instr;
    assign if_pc    = r_if_pc;
    assign fault    = (r_state == S_FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = S_RUN;
        end else if (!w_stall && (r_state == S_RUN) && !w_pc_ok) begin
            w_state_next = S_FAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc       <= RESET_PC;
            r_inflight_pc    <= 32'h0;
            r_inflight_valid <= 1'b0;
            r_if_valid       <= 1'b0;
            r_if_instr       <= 32'h0;
            r_if_pc          <= 32'h0;
        end else if (redirect_valid) begin
            r_fetch_pc       <= w_target;
            r_inflight_valid <= 1'b0;
            r_if_valid       <= 1'b0;
        end else if (!w_stall) begin
            // Output slot is free (empty or consumed): refill from the bank.
            if (r_inflight_valid) begin
                r_if_instr <= imem_data;
                r_if_pc    <= r_inflight_pc;
                r_if_valid <= 1'b1;
            end else begin
                r_if_valid <= 1'b0;
            end

            if ((r_state == S_RUN) && w_pc_ok) begin
                r_inflight_pc    <= r_fetch_pc;
                r_inflight_valid <= 1'b1;
                r_fetch_pc       <= r_fetch_pc + 32'd4;
            end else begin
                r_inflight_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// Directed bench for fetch_unit: per-cycle vector table plus hand sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fault;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(256)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   mem_word = 32'hBC04_0007;
            32'd4:   mem_word = 32'hBC08_0005;
            32'd8:   mem_word = 32'h0048_C000;
            32'd12:  mem_word = 32'h840C_0000;
            32'd16:  mem_word = 32'h8010_0000;
            default: mem_word = 32'hC000_0000 | {2'b00, a[31:2]};
        endcase
    endfunction

    // Instruction bank: one-cycle registered read, no enable.
    always @(posedge clk) imem_data <= mem_word(imem_addr);

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        rv;
        logic [31:0] rt;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_fault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rdy, input logic rv, input logic [31:0] rt,
                       input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                       input logic ef);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rt = rt;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = ein; v.e_fault = ef;
        vecs.push_back(v);
    endtask

    task automatic check_out(input string name, input logic ev, input logic [31:0] epc,
                             input logic [31:0] ein, input logic ef);
        logic bad;
        n_tests++;
        bad = (if_valid !== ev) || (fault !== ef) ||
              (ev && ((if_pc !== epc) || (if_instr !== ein)));
        if (bad) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b pc=%h instr=%h fault=%0b, want valid=%0b pc=%h instr=%h fault=%0b",
                     name, if_valid, if_pc, if_instr, fault, ev, epc, ein, ef);
        end
    endtask

    task automatic check_addr(input string name, input logic [31:0] exp);
        n_tests++;
        if (imem_addr !== exp) begin
            n_fail++;
            $display("FAIL %s: imem_addr got %h want %h", name, imem_addr, exp);
        end
    endtask

    task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rt);
        reset = rst; if_ready = rdy; redirect_valid = rv; redirect_target = rt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0;

        // rst rdy rv target      valid pc        instr          fault
        add(1, 1, 0, 0,           0, 0,        0,             0);  // reset
        add(1, 1, 0, 0,           0, 0,        0,             0);
        add(0, 1, 0, 0,           0, 0,        0,             0);  // issue 0
        add(0, 1, 0, 0,           1, 0,        32'hBC04_0007, 0);
        add(0, 1, 0, 0,           1, 4,        32'hBC08_0005, 0);
        add(0, 0, 0, 0,           1, 4,        32'hBC08_0005, 0);  // stall x3
        add(0, 0, 0, 0,           1, 4,        32'hBC08_0005, 0);
        add(0, 0, 0, 0,           1, 4,        32'hBC08_0005, 0);
        add(0, 1, 0, 0,           1, 8,        32'h0048_C000, 0);
        add(0, 1, 0, 0,           1, 12,       32'h840C_0000, 0);
        add(0, 1, 0, 0,           1, 16,       32'h8010_0000, 0);
        add(0, 1, 0, 0,           1, 20,       32'hC000_0005, 0);
        add(0, 1, 1, 4,           0, 0,        0,             0);  // redirect to 4
        add(0, 1, 0, 0,           0, 0,        0,             0);
        add(0, 1, 0, 0,           1, 4,        32'hBC08_0005, 0);
        add(0, 1, 1, 16,          0, 0,        0,             0);  // redirect to 16
        add(0, 1, 0, 0,           0, 0,        0,             0);
        add(0, 1, 0, 0,           1, 16,       32'h8010_0000, 0);
        add(0, 1, 0, 0,           1, 20,       32'hC000_0005, 0);
        add(0, 1, 1, 32'h102,     0, 0,        0,             0);  // out-of-range target
        add(0, 1, 0, 0,           0, 0,        0,             1);
        add(0, 1, 0, 0,           0, 0,        0,             1);
        add(0, 1, 1, 0,           0, 0,        0,             0);  // recover
        add(0, 1, 0, 0,           0, 0,        0,             0);
        add(0, 1, 0, 0,           1, 0,        32'hBC04_0007, 0);
        add(0, 1, 1, 32'hF8,      0, 0,        0,             0);  // run to end of bank
        add(0, 1, 0, 0,           0, 0,        0,             0);
        add(0, 1, 0, 0,           1, 32'hF8,   32'hC000_003E, 0);
        add(0, 1, 0, 0,           1, 32'hFC,   32'hC000_003F, 1);
        add(0, 0, 0, 0,           1, 32'hFC,   32'hC000_003F, 1);  // drain held word
        add(0, 1, 0, 0,           0, 0,        0,             1);
        add(0, 1, 1, 0,           0, 0,        0,             0);
        add(0, 1, 0, 0,           0, 0,        0,             0);
        add(0, 1, 0, 0,           1, 0,        32'hBC04_0007, 0);
        add(0, 1, 0, 0,           1, 4,        32'hBC08_0005, 0);
        add(0, 0, 0, 0,           1, 4,        32'hBC08_0005, 0);
        add(0, 0, 1, 8,           0, 0,        0,             0);  // redirect during stall
        add(0, 0, 0, 0,           0, 0,        0,             0);
        add(0, 0, 0, 0,           1, 8,        32'h0048_C000, 0);
        add(0, 1, 0, 0,           1, 12,       32'h840C_0000, 0);
        add(0, 1, 0, 0,           1, 12,       32'h840C_0000, 0);  // row 40, expectation set below
        add(1, 1, 0, 0,           0, 0,        0,             0);  // reset mid-stream
        add(0, 1, 0, 0,           0, 0,        0,             0);
        add(0, 1, 0, 0,           1, 0,        32'hBC04_0007, 0);
        add(0, 1, 0, 0,           1, 4,        32'hBC08_0005, 0);
        // Row 40 follows pc 12: next accepted word is pc 16.
        vecs[40].e_pc = 16; vecs[40].e_instr = 32'h8010_0000;

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rt);
            check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                      vecs[i].e_instr, vecs[i].e_fault);
        end

        // Bank address replay: pc 4 shown, pc 8 in flight, fetch at 12.
        if_ready = 1'b0; #1;
        check_addr("replay_stall", 32'd8);
        if_ready = 1'b1; #1;
        check_addr("replay_release", 32'd12);

        // Reset wins over a simultaneous redirect and stall.
        step(1, 0, 1, 32'h40);
        check_out("rst_over_redirect", 0, 0, 0, 0);
        check_addr("rst_fetch_pc", 32'd0);
        step(0, 1, 0, 0);
        check_out("rst_restart_a", 0, 0, 0, 0);
        step(0, 1, 0, 0);
        check_out("rst_restart_b", 1, 0, 32'hBC04_0007, 0);
        step(0, 1, 0, 0);
        check_out("rst_restart_c", 1, 4, 32'hBC08_0005, 0);

        // Redirect alongside an accepted transfer: transfer consumed, then flush.
        step(0, 1, 1, 32'h0000_0013);
        check_out("redir_unaligned", 0, 0, 0, 0);
        step(0, 1, 0, 0);
        check_out("redir_unaligned_b", 0, 0, 0, 0);
        step(0, 1, 0, 0);
        check_out("redir_unaligned_c", 1, 16, 32'h8010_0000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
